// File: rtl/maze_carver_if.sv
// Game-controller <-> maze carver handshake plus the wall read port.
// step_tick is present only when MAZE_CARVER_ANIMATE_EN is defined.
interface maze_carver_if #(
    parameter int W  = 16,
    parameter int H  = 12,
    parameter int XW = $clog2(W),
    parameter int YW = $clog2(H)
);
    logic          carve;
    logic          finished_carve;
    logic          busy;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          rd_wall_e;
    logic          rd_wall_s;
`ifdef MAZE_CARVER_ANIMATE_EN
    logic          step_tick;

    modport master (
        output carve, rd_x, rd_y, step_tick,
        input  finished_carve, busy, cur_x, cur_y, rd_wall_e, rd_wall_s
    );
    modport slave (
        input  carve, rd_x, rd_y, step_tick,
        output finished_carve, busy, cur_x, cur_y, rd_wall_e, rd_wall_s
    );
`else
    modport master (
        output carve, rd_x, rd_y,
        input  finished_carve, busy, cur_x, cur_y, rd_wall_e, rd_wall_s
    );
    modport slave (
        input  carve, rd_x, rd_y,
        output finished_carve, busy, cur_x, cur_y, rd_wall_e, rd_wall_s
    );
`endif
endinterface

// File: rtl/maze_carver.sv
// Recursive-backtracker maze generator on a W x H grid with a registered wall read port.
// Optional MAZE_CARVER_ANIMATE_EN: WALK advances only on bus.step_tick.
module maze_carver #(
    parameter int          W    = 16,
    parameter int          H    = 12,
    parameter int          XW   = $clog2(W),
    parameter int          YW   = $clog2(H),
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    maze_carver_if.slave  bus
);
    localparam int NC = W * H;
    localparam int IW = $clog2(NC);

    typedef enum logic [1:0] {IDLE, INIT, WALK, DONE} state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         sp_q, sp_d;
    logic [XW-1:0]         cur_x_q, cur_x_d;
    logic [YW-1:0]         cur_y_q, cur_y_d;
    logic [NC-1:0]         wall_e_q, wall_e_d;
    logic [NC-1:0]         wall_s_q, wall_s_d;
    logic [NC-1:0]         visited_q, visited_d;
    logic [XW+YW-1:0]      stack_q [NC];
    logic [XW+YW-1:0]      stack_d [NC];
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  busy_q, busy_d;
    logic                  fin_q, fin_d;
    logic                  rd_e_q, rd_e_d;
    logic                  rd_s_q, rd_s_d;

    logic [3:0]            cand;
    logic                  found;
    logic [1:0]            dir;
    logic [XW-1:0]         nx;
    logic [YW-1:0]         ny;
    logic                  walk_en;

    function automatic logic [IW-1:0] cidx(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(int'(y) * W + int'(x));
    endfunction

`ifdef MAZE_CARVER_ANIMATE_EN
    assign walk_en = bus.step_tick;
`else
    assign walk_en = 1'b1;
`endif

    // Neighbour selection: first free direction in N,E,S,W order, rotated to start at lfsr[1:0].
    always_comb begin
        cand    = '0;
        cand[0] = (cur_y_q != '0) && !visited_q[cidx(cur_x_q, cur_y_q - YW'(1))];
        cand[1] = (int'(cur_x_q) < W - 1) && !visited_q[cidx(cur_x_q + XW'(1), cur_y_q)];
        cand[2] = (int'(cur_y_q) < H - 1) && !visited_q[cidx(cur_x_q, cur_y_q + YW'(1))];
        cand[3] = (cur_x_q != '0) && !visited_q[cidx(cur_x_q - XW'(1), cur_y_q)];
        found   = 1'b0;
        dir     = lfsr_q[1:0];
        for (int unsigned k = 0; k < 4; k++) begin
            if (!found && cand[lfsr_q[1:0] + 2'(k)]) begin
                found = 1'b1;
                dir   = lfsr_q[1:0] + 2'(k);
            end
        end
        nx = cur_x_q;
        ny = cur_y_q;
        unique case (dir)
            2'd0:    ny = cur_y_q - YW'(1);
            2'd1:    nx = cur_x_q + XW'(1);
            2'd2:    ny = cur_y_q + YW'(1);
            default: nx = cur_x_q - XW'(1);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sp_d      = sp_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        wall_e_d  = wall_e_q;
        wall_s_d  = wall_s_q;
        visited_d = visited_q;
        stack_d   = stack_q;
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        unique case (state_q)
            IDLE: begin
                if (bus.carve) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            INIT: begin
                if (!bus.carve) begin
                    state_d = IDLE;
                end else begin
                    wall_e_d[cnt_q]  = 1'b1;
                    wall_s_d[cnt_q]  = 1'b1;
                    visited_d[cnt_q] = 1'b0;
                    if (cnt_q == IW'(NC - 1)) begin
                        cur_x_d      = '0;
                        cur_y_d      = '0;
                        visited_d[0] = 1'b1;
                        sp_d         = '0;
                        state_d      = WALK;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            WALK: begin
                if (!bus.carve) begin
                    state_d = IDLE;
                end else if (walk_en) begin
                    if (found) begin
                        // N and W openings live in the neighbour's south/east bit.
                        unique case (dir)
                            2'd0:    wall_s_d[cidx(nx, ny)]           = 1'b0;
                            2'd1:    wall_e_d[cidx(cur_x_q, cur_y_q)] = 1'b0;
                            2'd2:    wall_s_d[cidx(cur_x_q, cur_y_q)] = 1'b0;
                            default: wall_e_d[cidx(nx, ny)]           = 1'b0;
                        endcase
                        stack_d[sp_q]           = {cur_x_q, cur_y_q};
                        sp_d                    = sp_q + IW'(1);
                        visited_d[cidx(nx, ny)] = 1'b1;
                        cur_x_d                 = nx;
                        cur_y_d                 = ny;
                    end else if (sp_q != '0) begin
                        {cur_x_d, cur_y_d} = stack_q[sp_q - IW'(1)];
                        sp_d               = sp_q - IW'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                if (!bus.carve) state_d = IDLE;
            end
        endcase

        busy_d = (state_d == INIT) || (state_d == WALK);
        fin_d  = (state_d == DONE);

        if ((int'(bus.rd_x) < W) && (int'(bus.rd_y) < H)) begin
            rd_e_d = wall_e_q[cidx(bus.rd_x, bus.rd_y)];
            rd_s_d = wall_s_q[cidx(bus.rd_x, bus.rd_y)];
        end else begin
            rd_e_d = 1'b1;
            rd_s_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sp_q      <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            wall_e_q  <= '1;
            wall_s_q  <= '1;
            visited_q <= '0;
            stack_q   <= '{default: '0};
            lfsr_q    <= SEED;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
            rd_e_q    <= 1'b1;
            rd_s_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sp_q      <= sp_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            wall_e_q  <= wall_e_d;
            wall_s_q  <= wall_s_d;
            visited_q <= visited_d;
            stack_q   <= stack_d;
            lfsr_q    <= lfsr_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
            rd_e_q    <= rd_e_d;
            rd_s_q    <= rd_s_d;
        end
    end

    assign bus.finished_carve = fin_q;
    assign bus.busy           = busy_q;
    assign bus.cur_x          = cur_x_q;
    assign bus.cur_y          = cur_y_q;
    assign bus.rd_wall_e      = rd_e_q;
    assign bus.rd_wall_s      = rd_s_q;
endmodule

// File: tb/tb_maze_carver.sv
// Directed bench for maze_carver: 4x4 main instance plus a 3x3 instance for out-of-range reads.
// Also exercises MAZE_CARVER_ANIMATE_EN when that macro is defined.
module tb_maze_carver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maze_carver_if #(.W(4), .H(4), .XW(2), .YW(2)) bus_a ();
    maze_carver_if #(.W(3), .H(3), .XW(2), .YW(2)) bus_b ();

    maze_carver #(.W(4), .H(4), .XW(2), .YW(2), .SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    maze_carver #(.W(3), .H(3), .XW(2), .YW(2), .SEED(16'h1D2B)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    typedef struct {
        int edge_n;
        bit carve;
        bit exp_busy;
        bit exp_fin;
        int exp_fin3;   // -1: not checked
        int exp_x;      // -1: cur not checked
        int exp_y;
    } vec_t;

    vec_t vecs [14];
    int pass_cnt = 0;
    int tot_cnt  = 0;
    int ecnt     = 0;
    logic [15:0] we_a, ws_a, we_b, ws_b, we_n, ws_n;

    task automatic check(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step_to(input int n);
        while (ecnt < n) begin
            @(posedge clk);
            ecnt++;
        end
        #1;
    endtask

    task automatic run_vec(input int i);
        step_to(vecs[i].edge_n);
        check($sformatf("busy@%0d", vecs[i].edge_n), int'(bus_a.busy), int'(vecs[i].exp_busy));
        check($sformatf("fin@%0d", vecs[i].edge_n), int'(bus_a.finished_carve), int'(vecs[i].exp_fin));
        if (vecs[i].exp_fin3 >= 0)
            check($sformatf("fin3@%0d", vecs[i].edge_n), int'(bus_b.finished_carve), vecs[i].exp_fin3);
        if (vecs[i].exp_x >= 0) begin
            check($sformatf("cur_x@%0d", vecs[i].edge_n), int'(bus_a.cur_x), vecs[i].exp_x);
            check($sformatf("cur_y@%0d", vecs[i].edge_n), int'(bus_a.cur_y), vecs[i].exp_y);
        end
        bus_a.carve = vecs[i].carve;
    endtask

    // Reads every (x,y) in 0..3 from both instances, one cell per edge.
    task automatic read_all(output logic [15:0] ea, output logic [15:0] sa,
                            output logic [15:0] eb, output logic [15:0] sb);
        for (int c = 0; c < 16; c++) begin
            bus_a.rd_x = 2'(c % 4);
            bus_a.rd_y = 2'(c / 4);
            bus_b.rd_x = 2'(c % 4);
            bus_b.rd_y = 2'(c / 4);
            @(posedge clk);
            ecnt++;
            #1;
            ea[c] = bus_a.rd_wall_e;
            sa[c] = bus_a.rd_wall_s;
            eb[c] = bus_b.rd_wall_e;
            sb[c] = bus_b.rd_wall_s;
        end
    endtask

    function automatic int reach(input logic [15:0] e, input logic [15:0] s);
        logic [15:0] r = 16'h0001;
        for (int it = 0; it < 16; it++) begin
            for (int c = 0; c < 16; c++) begin
                if (r[c]) begin
                    if (c % 4 < 3 && !e[c])     r[c + 1] = 1'b1;
                    if (c / 4 < 3 && !s[c])     r[c + 4] = 1'b1;
                    if (c % 4 > 0 && !e[c - 1]) r[c - 1] = 1'b1;
                    if (c / 4 > 0 && !s[c - 4]) r[c - 4] = 1'b1;
                end
            end
        end
        return $countones(r);
    endfunction

    task automatic maze_props(input string tag);
        check({tag, "_ones"}, $countones(we_a) + $countones(ws_a), 17);
        check({tag, "_east_edge"}, int'({we_a[3], we_a[7], we_a[11], we_a[15]}), 15);
        check({tag, "_south_edge"}, int'(ws_a[15:12]), 15);
        check({tag, "_reach"}, reach(we_a, ws_a), 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones3, oor0;
        vecs[0]  = '{0,  1, 0, 0,  0,  0,  0};
        vecs[1]  = '{1,  1, 1, 0,  0, -1, -1};
        vecs[2]  = '{17, 1, 1, 0,  0,  0,  0};
        vecs[3]  = '{26, 1, 1, 0,  0, -1, -1};
        vecs[4]  = '{27, 1, 1, 0,  1, -1, -1};
        vecs[5]  = '{47, 1, 1, 0, -1, -1, -1};
        vecs[6]  = '{48, 1, 0, 1,  1,  0,  0};
        vecs[7]  = '{0,  1, 0, 0, -1, -1, -1};
        vecs[8]  = '{1,  1, 1, 0, -1, -1, -1};
        vecs[9]  = '{30, 0, 1, 0, -1, -1, -1};
        vecs[10] = '{31, 1, 0, 0, -1, -1, -1};
        vecs[11] = '{32, 1, 1, 0, -1, -1, -1};
        vecs[12] = '{78, 1, 1, 0, -1, -1, -1};
        vecs[13] = '{79, 1, 0, 1, -1,  0,  0};

        bus_a.carve = 1'b0; bus_a.rd_x = 2'd2; bus_a.rd_y = 2'd1;
        bus_b.carve = 1'b0; bus_b.rd_x = 2'd0; bus_b.rd_y = 2'd0;
`ifdef MAZE_CARVER_ANIMATE_EN
        bus_a.step_tick = 1'b1;
        bus_b.step_tick = 1'b1;
`endif
        #2;
        check("rst_busy", int'(bus_a.busy), 0);
        check("rst_fin", int'(bus_a.finished_carve), 0);
        check("rst_cur", int'({bus_a.cur_x, bus_a.cur_y}), 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rd_e", int'(bus_a.rd_wall_e), 1);
        check("rst_rd_s", int'(bus_a.rd_wall_s), 1);

        // Full generation run.
        ecnt = 0;
        bus_b.carve = 1'b1;
        for (int i = 0; i < 7; i++) run_vec(i);
        read_all(we_a, ws_a, we_b, ws_b);
        maze_props("mazeA");
        ones3 = 0;
        oor0  = 0;
        for (int c = 0; c < 16; c++) begin
            if (c % 4 < 3 && c / 4 < 3) ones3 += int'(we_b[c]) + int'(ws_b[c]);
            else oor0 += int'(!we_b[c]) + int'(!ws_b[c]);
        end
        check("m3_ones", ones3, 10);
        check("m3_oor", oor0, 0);

        // Drop carve in DONE: finished falls on the next edge, walls retained.
        check("done_hold_fin", int'(bus_a.finished_carve), 1);
        bus_a.carve = 1'b0;
        @(posedge clk);
        #1;
        check("drop_fin", int'(bus_a.finished_carve), 0);
        check("drop_busy", int'(bus_a.busy), 0);
        read_all(we_n, ws_n, we_b, ws_b);
        check("retain_e", int'(we_n), int'(we_a));
        check("retain_s", int'(ws_n), int'(ws_a));

        // Abort mid-WALK, then a full re-run.
        ecnt = 0;
        for (int i = 7; i < 14; i++) run_vec(i);
        read_all(we_a, ws_a, we_b, ws_b);
        maze_props("mazeB");

`ifdef MAZE_CARVER_ANIMATE_EN
        begin
            int ticks, moved_off_tick, done_edge;
            logic [3:0] prev;
            bus_a.carve = 1'b0;
            @(posedge clk);
            #1;
            ticks = 0; moved_off_tick = 0; done_edge = -1;
            bus_a.step_tick = 1'b0;
            bus_a.carve = 1'b1;
            for (int k = 1; k <= 400 && done_edge < 0; k++) begin
                bus_a.step_tick = (k % 4 == 0);
                prev = {bus_a.cur_x, bus_a.cur_y};
                @(posedge clk);
                #1;
                if (!bus_a.step_tick && prev != {bus_a.cur_x, bus_a.cur_y}) moved_off_tick++;
                if (k >= 18 && bus_a.step_tick) ticks++;
                if (bus_a.finished_carve) done_edge = k;
            end
            check("anim_done", int'(done_edge > 0), 1);
            check("anim_ticks", ticks, 31);
            check("anim_still", moved_off_tick, 0);
            bus_a.step_tick = 1'b1;
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
